// File: rtl/rf_mp_sb_pkg.sv
// Shared defaults for the multi-port register file and its busy scoreboard.
package rf_mp_sb_pkg;
  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int NR_DEF   = 2;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/rf_mp_sb_scoreboard.sv
// Per-register busy bits for outstanding load results, plus registered busy count.
module rf_mp_sb_scoreboard
  import rf_mp_sb_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_v,
  input  logic [AW-1:0]        iss_wn,
  input  logic                 flush,
  input  logic                 we0,
  input  logic [AW-1:0]        wn0,
  input  logic                 we1,
  input  logic [AW-1:0]        wn1,
  output logic [(1<<AW)-1:0]   busy,
  output logic [AW:0]          busy_cnt
);
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  logic [DEPTH-1:0] r_busy, w_busy_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  // Clears first, then the issue set, so a same-cycle issue wins over a write
  always_comb begin
    w_busy_nxt = r_busy;
    w_cnt_nxt  = '0;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (we0)   w_busy_nxt[wn0]    = 1'b0;
      if (we1)   w_busy_nxt[wn1]    = 1'b0;
      if (iss_v) w_busy_nxt[iss_wn] = 1'b1;
    end
    w_busy_nxt[REG_ZERO] = 1'b0;
    for (int i = 0; i < DEPTH; i++) w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign busy     = r_busy;
  assign busy_cnt = r_cnt;
endmodule

// File: rtl/rf_mp_sb.sv
// NR-read / 2-write register file with optional write->read bypass and load-use scoreboard.
module rf_mp_sb
  import rf_mp_sb_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int NR     = NR_DEF,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR*AW-1:0]   ra,
  output logic [NR*DW-1:0]   qa,
  output logic [NR-1:0]      rd_rdy,
  input  logic               we0,
  input  logic [AW-1:0]      wn0,
  input  logic [DW-1:0]      d0,
  input  logic               we1,
  input  logic [AW-1:0]      wn1,
  input  logic [DW-1:0]      d1,
  input  logic               iss_v,
  input  logic [AW-1:0]      iss_wn,
  input  logic               flush,
  output logic [AW:0]        busy_cnt
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    r_rf [DEPTH];
  logic [DEPTH-1:0] w_busy;
  logic             w_wr0, w_wr1;

  assign w_wr0 = we0 && (wn0 != AW'(REG_ZERO));
  assign w_wr1 = we1 && (wn1 != AW'(REG_ZERO));

  // Port 1 is assigned last so it wins a same-address collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
    end else begin
      if (w_wr0) r_rf[wn0] <= d0;
      if (w_wr1) r_rf[wn1] <= d1;
    end
  end

  for (genvar g = 0; g < NR; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_zero, w_hit0, w_hit1;
    assign w_ra      = ra[g*AW +: AW];
    assign w_zero    = (w_ra == AW'(REG_ZERO));
    assign w_hit0    = (BYPASS != 0) && w_wr0 && (wn0 == w_ra);
    assign w_hit1    = (BYPASS != 0) && w_wr1 && (wn1 == w_ra);
    assign qa[g*DW +: DW] = w_zero ? '0 : w_hit1 ? d1 : w_hit0 ? d0 : r_rf[w_ra];
    assign rd_rdy[g] = w_zero | ~w_busy[w_ra] | w_hit0 | w_hit1;
  end

  rf_mp_sb_scoreboard #(.AW(AW)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_v    (iss_v),
    .iss_wn   (iss_wn),
    .flush    (flush),
    .we0      (we0),
    .wn0      (wn0),
    .we1      (we1),
    .wn1      (wn1),
    .busy     (w_busy),
    .busy_cnt (busy_cnt)
  );
endmodule
